// File: rtl/gen_fifo.sv
// Single-clock register-array FIFO between the byte generator and its consumer.
// Define GEN_FIFO_ERR_FLAGS_EN to add the sticky ovf/udf error outputs.
module gen_fifo #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AF_LEVEL = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sclr,
  input  logic                     wrreq,
  input  logic [WIDTH-1:0]         data,
  output logic                     full,
  output logic                     almost_full,
  input  logic                     rdreq,
  output logic [WIDTH-1:0]         q,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   usedw
`ifdef GEN_FIFO_ERR_FLAGS_EN
  ,
  output logic                     ovf,
  output logic                     udf
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DepthCnt = (AW+1)'(DEPTH);
  localparam logic [AW:0] AfCnt    = (AW+1)'(AF_LEVEL);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      usedw_nxt;
  logic             wr_acc;
  logic             rd_acc;

  // Acceptance uses the registered flags, so simultaneous requests at the
  // boundaries resolve from the state before the edge.
  assign wr_acc = wrreq && !full;
  assign rd_acc = rdreq && !empty;

  always_comb begin
    usedw_nxt = usedw;
    if (wr_acc && !rd_acc) begin
      usedw_nxt = usedw + 1'b1;
    end else if (rd_acc && !wr_acc) begin
      usedw_nxt = usedw - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr        <= '0;
      rptr        <= '0;
      usedw       <= '0;
      empty       <= 1'b1;
      full        <= 1'b0;
      almost_full <= 1'b0;
      q           <= '0;
    end else if (sclr) begin
      wptr        <= '0;
      rptr        <= '0;
      usedw       <= '0;
      empty       <= 1'b1;
      full        <= 1'b0;
      almost_full <= 1'b0;
      q           <= '0;
    end else begin
      if (wr_acc) begin
        wptr <= wptr + 1'b1;
      end
      if (rd_acc) begin
        rptr <= rptr + 1'b1;
        q    <= mem[rptr];
      end
      usedw       <= usedw_nxt;
      empty       <= (usedw_nxt == '0);
      full        <= (usedw_nxt == DepthCnt);
      almost_full <= (usedw_nxt >= AfCnt);
    end
  end

  // Storage needs no reset; contents are only observable after a write.
  always_ff @(posedge clk) begin
    if (wr_acc && !sclr) begin
      mem[wptr] <= data;
    end
  end

`ifdef GEN_FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else if (sclr) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (wrreq && full) begin
        ovf <= 1'b1;
      end
      if (rdreq && empty) begin
        udf <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_gen_fifo.sv
// Scoreboard bench for gen_fifo: a queue-based reference model predicts contents,
// flags and read data; a negedge monitor compares the DUT against it.
module tb_gen_fifo;

  localparam int D  = 16;
  localparam int AF = 12;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sclr, wrreq, rdreq;
  logic [7:0] data, q;
  logic       full, almost_full, empty;
  logic [4:0] usedw;
`ifdef GEN_FIFO_ERR_FLAGS_EN
  logic       ovf, udf;
`endif

  gen_fifo #(.WIDTH(8), .DEPTH(D), .AF_LEVEL(AF)) dut (
    .clk         (clk),
    .rst         (rst),
    .sclr        (sclr),
    .wrreq       (wrreq),
    .data        (data),
    .full        (full),
    .almost_full (almost_full),
    .rdreq       (rdreq),
    .q           (q),
    .empty       (empty),
    .usedw       (usedw)
`ifdef GEN_FIFO_ERR_FLAGS_EN
    ,
    .ovf         (ovf),
    .udf         (udf)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state
  logic [7:0] mq[$];
  logic [7:0] sb[$];
  logic [7:0] qhold = 8'h00;
  bit         rd_vld = 1'b0;
  bit         movf = 1'b0;
  bit         mudf = 1'b0;
  bit         started = 1'b0;
  int         acc_w = 0;
  int         sb_idx = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_clear();
    mq.delete();
    qhold  = 8'h00;
    rd_vld = 1'b0;
    movf   = 1'b0;
    mudf   = 1'b0;
  endtask

  // Drive one cycle of requests, then update the model to what the edge must produce.
  task automatic step(input bit w, input bit r, input logic [7:0] d, input bit c = 1'b0);
    bit wa, ra;
    wrreq = w;
    rdreq = r;
    data  = d;
    sclr  = c;
    @(posedge clk);
    #1;
    rd_vld = 1'b0;
    if (c) begin
      model_clear();
    end else begin
      wa = w && (mq.size() < D);
      ra = r && (mq.size() > 0);
      if (w && mq.size() == D) movf = 1'b1;
      if (r && mq.size() == 0) mudf = 1'b1;
      if (ra) begin
        qhold = mq.pop_front();
        sb.push_back(qhold);
        rd_vld = 1'b1;
      end
      if (wa) begin
        mq.push_back(d);
        acc_w++;
      end
    end
    @(negedge clk);
  endtask

  // Monitor: compare flags every cycle and pop the scoreboard after each accepted read.
  always @(negedge clk) begin
    if (started && !rst) begin
      chk("usedw", int'(usedw), mq.size());
      chk("full", int'(full), int'(mq.size() == D));
      chk("empty", int'(empty), int'(mq.size() == 0));
      chk("almost_full", int'(almost_full), int'(mq.size() >= AF));
      if (rd_vld) begin
        if (sb_idx < sb.size()) chk("q_read", int'(q), int'(sb[sb_idx]));
        else chk("q_read_missing", 0, 1);
        sb_idx++;
      end else begin
        chk("q_hold", int'(q), int'(qhold));
      end
`ifdef GEN_FIFO_ERR_FLAGS_EN
      chk("ovf", int'(ovf), int'(movf));
      chk("udf", int'(udf), int'(mudf));
`endif
    end
  end

  initial begin
    int a0;
    sclr = 1'b0; wrreq = 1'b0; rdreq = 1'b0; data = 8'h00;
    #1 rst = 1'b1;
    #10;
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_af", int'(almost_full), 0);
    chk("rst_usedw", int'(usedw), 0);
    chk("rst_q", int'(q), 0);
    @(negedge clk);
    rst = 1'b0;
    started = 1'b1;

    repeat (5) step(1'b0, 1'b0, 8'h00);

    // Fill, overflow, drain, underflow
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(i));
    chk("fill_full", int'(full), 1);
    step(1'b1, 1'b0, 8'hAA);
    chk("ovf_usedw", int'(usedw), 16);
    repeat (16) step(1'b0, 1'b1, 8'h00);
    chk("drain_empty", int'(empty), 1);
    chk("drain_last_q", int'(q), 8'h0F);
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 8'h00, 1'b1);

    // Pointer wrap
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'(8'h10 + i));
    repeat (10) step(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 8'(8'h20 + i));
    repeat (12) step(1'b0, 1'b1, 8'h00);
    chk("wrap_usedw", int'(usedw), 0);
    chk("wrap_last_q", int'(q), 8'h2B);

    // Simultaneous requests: mid, full, empty
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h40 + i));
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 8'(8'h50 + i));
    chk("simul_usedw", int'(usedw), 5);
    repeat (5) step(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(8'h60 + i));
    step(1'b1, 1'b1, 8'hEE);
    chk("simul_full_usedw", int'(usedw), 15);
    repeat (15) step(1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b1, 8'h77);
    chk("simul_empty_usedw", int'(usedw), 1);
    chk("simul_empty_q", int'(q), 8'h6F);
    step(1'b0, 1'b1, 8'h00);

    // Back-pressure with wrreq held high
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(8'h80 + i));
    a0 = acc_w;
    step(1'b1, 1'b1, 8'h90);
    chk("bp_full_drop", int'(full), 0);
    step(1'b1, 1'b0, 8'h91);
    step(1'b1, 1'b0, 8'h92);
    step(1'b1, 1'b1, 8'h93);
    step(1'b1, 1'b0, 8'h94);
    step(1'b1, 1'b0, 8'h95);
    chk("bp_accepted", acc_w - a0, 2);

    // Synchronous clear at usedw=7
    repeat (9) step(1'b0, 1'b1, 8'h00);
    chk("pre_sclr_usedw", int'(usedw), 7);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("sclr_usedw", int'(usedw), 0);
    chk("sclr_q", int'(q), 0);

    // Asynchronous reset mid-cycle at usedw=7
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(8'hC0 + i));
    step(1'b0, 1'b1, 8'h00);
    #2 rst = 1'b1;
    model_clear();
    #1;
    chk("arst_usedw", int'(usedw), 0);
    chk("arst_empty", int'(empty), 1);
    chk("arst_q", int'(q), 0);
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 1'b0, 8'h55);
    step(1'b1, 1'b0, 8'h66);
    step(1'b0, 1'b1, 8'h00);
    chk("post_rst_first", int'(q), 8'h55);
    step(1'b0, 1'b1, 8'h00);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      step(bit'($urandom_range(0, 99) < 55), bit'($urandom_range(0, 99) < 50),
           8'($urandom), bit'($urandom_range(0, 99) < 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
